// File: rtl/execute_stage_md.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : execute_stage_md                                             |
// | Description : Execute stage with single-cycle ALU, two-level operand       |
// |               forwarding, EX/MEM pipeline register and an iterative        |
// |               radix-2 multiply/divide unit (RV32M-style op set).           |
// | Ports       : clk, rst_n (async, active-low)                               |
// |               memory_stall / flush          - pipeline control            |
// |               data1, data2, immediate       - ID/EX operands              |
// |               rs1_2, rs2_2, rd_2, write_back_2, mem_2, alu_op_2,          |
// |               alu_src_2                     - ID/EX op fields             |
// |               writeback_data_5, write_back_5, rd_5 - MEM/WB forwarding    |
// |               write_back_3, mem_3, alu_result_3, writedata_3, rd_3        |
// |                                             - EX/MEM register             |
// |               ex_stall                      - hold ID/EX (combinational)  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module execute_stage_md #(
    parameter int XLEN    = 32,
    parameter int REG_W   = 5,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             memory_stall,
    input  logic             flush,
    input  logic [XLEN-1:0]  data1,
    input  logic [XLEN-1:0]  data2,
    input  logic [XLEN-1:0]  immediate,
    input  logic [REG_W-1:0] rs1_2,
    input  logic [REG_W-1:0] rs2_2,
    input  logic [REG_W-1:0] rd_2,
    input  logic             write_back_2,
    input  logic [1:0]       mem_2,
    input  logic [4:0]       alu_op_2,
    input  logic             alu_src_2,
    input  logic [XLEN-1:0]  writeback_data_5,
    input  logic             write_back_5,
    input  logic [REG_W-1:0] rd_5,
    output logic             write_back_3,
    output logic [1:0]       mem_3,
    output logic [XLEN-1:0]  alu_result_3,
    output logic [XLEN-1:0]  writedata_3,
    output logic [REG_W-1:0] rd_3,
    output logic             ex_stall
);
    localparam int               CNT_W       = $clog2(XLEN);
    localparam logic [CNT_W-1:0] c_last_iter = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  c_int_min   = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [4:0] c_op_sub   = 5'd1;
    localparam logic [4:0] c_op_and   = 5'd2;
    localparam logic [4:0] c_op_or    = 5'd3;
    localparam logic [4:0] c_op_xor   = 5'd4;
    localparam logic [4:0] c_op_sll   = 5'd5;
    localparam logic [4:0] c_op_srl   = 5'd6;
    localparam logic [4:0] c_op_sra   = 5'd7;
    localparam logic [4:0] c_op_slt   = 5'd8;
    localparam logic [4:0] c_op_sltu  = 5'd9;
    localparam logic [4:0] c_op_mul   = 5'd10;
    localparam logic [4:0] c_op_mulh  = 5'd11;
    localparam logic [4:0] c_op_mulhu = 5'd12;
    localparam logic [4:0] c_op_div   = 5'd13;
    localparam logic [4:0] c_op_divu  = 5'd14;
    localparam logic [4:0] c_op_rem   = 5'd15;
    localparam logic [4:0] c_op_remu  = 5'd16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state, w_state_nx;
    logic [CNT_W-1:0]   r_cnt;
    logic [4:0]         r_mop;
    logic               r_neg;
    logic [XLEN-1:0]    r_hi, r_lo, r_b, r_result;

    logic [XLEN-1:0]    w_fwd1, w_fwd2, w_op2, w_alu, w_result;
    logic [SHAMT_W-1:0] w_shamt;
    logic               w_is_m, w_is_div, w_is_rem, w_signed, w_a_neg, w_b_neg;
    logic               w_div0, w_ovf, w_shortcut, w_issue;
    logic [XLEN-1:0]    w_a_mag, w_b_mag, w_short_res;
    logic [XLEN:0]      w_sum, w_trial;
    logic [XLEN-1:0]    w_hi_nx, w_lo_nx, w_final;
    logic [2*XLEN-1:0]  w_prod, w_prod_neg;

    // EX/MEM hit wins over MEM/WB; register 0 never forwards.
    always_comb begin
        w_fwd1 = data1;
        if (write_back_3 && rd_3 != '0 && rd_3 == rs1_2)
            w_fwd1 = alu_result_3;
        else if (write_back_5 && rd_5 != '0 && rd_5 == rs1_2)
            w_fwd1 = writeback_data_5;
        w_fwd2 = data2;
        if (write_back_3 && rd_3 != '0 && rd_3 == rs2_2)
            w_fwd2 = alu_result_3;
        else if (write_back_5 && rd_5 != '0 && rd_5 == rs2_2)
            w_fwd2 = writeback_data_5;
    end

    assign w_op2   = alu_src_2 ? immediate : w_fwd2;
    assign w_shamt = w_op2[SHAMT_W-1:0];

    always_comb begin
        w_alu = w_fwd1 + w_op2;
        case (alu_op_2)
            c_op_sub:  w_alu = w_fwd1 - w_op2;
            c_op_and:  w_alu = w_fwd1 & w_op2;
            c_op_or:   w_alu = w_fwd1 | w_op2;
            c_op_xor:  w_alu = w_fwd1 ^ w_op2;
            c_op_sll:  w_alu = w_fwd1 << w_shamt;
            c_op_srl:  w_alu = w_fwd1 >> w_shamt;
            c_op_sra:  w_alu = $signed(w_fwd1) >>> w_shamt;
            c_op_slt:  w_alu = {{(XLEN-1){1'b0}}, $signed(w_fwd1) < $signed(w_op2)};
            c_op_sltu: w_alu = {{(XLEN-1){1'b0}}, w_fwd1 < w_op2};
            default:   ;
        endcase
    end

    // M-op decode and issue-time operand preparation (operand 2 is always fwd2).
    assign w_is_m      = (alu_op_2 >= c_op_mul) && (alu_op_2 <= c_op_remu);
    assign w_is_div    = (alu_op_2 >= c_op_div) && (alu_op_2 <= c_op_remu);
    assign w_is_rem    = (alu_op_2 == c_op_rem) || (alu_op_2 == c_op_remu);
    assign w_signed    = (alu_op_2 == c_op_mulh) || (alu_op_2 == c_op_div) ||
                         (alu_op_2 == c_op_rem);
    assign w_a_neg     = w_signed & w_fwd1[XLEN-1];
    assign w_b_neg     = w_signed & w_fwd2[XLEN-1];
    assign w_a_mag     = w_a_neg ? -w_fwd1 : w_fwd1;
    assign w_b_mag     = w_b_neg ? -w_fwd2 : w_fwd2;
    assign w_div0      = w_is_div && (w_fwd2 == '0);
    assign w_ovf       = ((alu_op_2 == c_op_div) || (alu_op_2 == c_op_rem)) &&
                         (w_fwd1 == c_int_min) && (w_fwd2 == '1);
    assign w_shortcut  = w_div0 | w_ovf;
    assign w_short_res = w_div0 ? (w_is_rem ? w_fwd1 : '1)
                                : (w_is_rem ? '0 : w_fwd1);
    assign w_issue     = (r_state == S_IDLE) && w_is_m && !flush;
    assign ex_stall    = w_is_m && (r_state != S_DONE) && !flush;

    // One radix-2 step. Multiply: {hi,lo} shifts right while adding b into hi.
    // Divide: {hi,lo} shifts left, quotient bits enter lo, hi is the remainder.
    assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    assign w_trial = {r_hi, r_lo[XLEN-1]} - {1'b0, r_b};

    always_comb begin
        if (r_mop >= c_op_div) begin
            w_hi_nx = w_trial[XLEN] ? {r_hi[XLEN-2:0], r_lo[XLEN-1]} : w_trial[XLEN-1:0];
            w_lo_nx = {r_lo[XLEN-2:0], ~w_trial[XLEN]};
        end else begin
            w_hi_nx = w_sum[XLEN:1];
            w_lo_nx = {w_sum[0], r_lo[XLEN-1:1]};
        end
    end

    assign w_prod     = {w_hi_nx, w_lo_nx};
    assign w_prod_neg = -w_prod;

    // Sign correction on the value produced by the final step.
    always_comb begin
        case (r_mop)
            c_op_mul:   w_final = w_lo_nx;
            c_op_mulh:  w_final = r_neg ? w_prod_neg[2*XLEN-1:XLEN] : w_hi_nx;
            c_op_mulhu: w_final = w_hi_nx;
            c_op_div:   w_final = r_neg ? -w_lo_nx : w_lo_nx;
            c_op_divu:  w_final = w_lo_nx;
            c_op_rem:   w_final = r_neg ? -w_hi_nx : w_hi_nx;
            default:    w_final = w_hi_nx;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:  if (w_issue) w_state_nx = w_shortcut ? S_DONE : S_RUN;
            S_RUN:   if (r_cnt == c_last_iter) w_state_nx = S_DONE;
            S_DONE:  if (!memory_stall) w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
        if (flush)
            w_state_nx = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_mop    <= '0;
            r_neg    <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
            r_result <= '0;
        end else if (w_issue) begin
            r_cnt <= '0;
            r_mop <= alu_op_2;
            r_neg <= w_is_rem ? w_a_neg : (w_a_neg ^ w_b_neg);
            r_hi  <= '0;
            r_lo  <= w_a_mag;
            r_b   <= w_b_mag;
            if (w_shortcut)
                r_result <= w_short_res;
        end else if (r_state == S_RUN && !flush) begin
            r_cnt <= r_cnt + 1'b1;
            r_hi  <= w_hi_nx;
            r_lo  <= w_lo_nx;
            if (r_cnt == c_last_iter)
                r_result <= w_final;
        end
    end

    assign w_result = (w_is_m && r_state == S_DONE) ? r_result : w_alu;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_back_3 <= 1'b0;
            mem_3        <= '0;
            alu_result_3 <= '0;
            writedata_3  <= '0;
            rd_3         <= '0;
        end else if (memory_stall) begin
            write_back_3 <= write_back_3;
        end else if (flush || ex_stall) begin
            write_back_3 <= 1'b0;
            mem_3        <= '0;
            alu_result_3 <= '0;
            writedata_3  <= '0;
            rd_3         <= '0;
        end else begin
            write_back_3 <= write_back_2;
            mem_3        <= mem_2;
            alu_result_3 <= w_result;
            writedata_3  <= w_fwd2;
            rd_3         <= rd_2;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_execute_stage_md.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_execute_stage_md                                          |
// | Description : Scoreboard bench for execute_stage_md (XLEN=32). A driver    |
// |               pushes expected EX/MEM contents computed by an arithmetic    |
// |               reference model; a monitor pops and compares them whenever   |
// |               a new writeback result is registered.                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_execute_stage_md;
    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        memory_stall, flush;
    logic [31:0] data1, data2, immediate, writeback_data_5;
    logic [4:0]  rs1_2, rs2_2, rd_2, rd_5, alu_op_2;
    logic        write_back_2, alu_src_2, write_back_5;
    logic [1:0]  mem_2;
    logic        write_back_3, ex_stall;
    logic [1:0]  mem_3;
    logic [31:0] alu_result_3, writedata_3;
    logic [4:0]  rd_3;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] res;
        logic [31:0] wd;
        logic [1:0]  mem;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Model view of the EX/MEM register, used for forwarding predictions.
    logic        m_wb3  = 1'b0;
    logic [4:0]  m_rd3  = '0;
    logic [31:0] m_res3 = '0;

    execute_stage_md #(.XLEN(XLEN), .REG_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .memory_stall(memory_stall), .flush(flush),
        .data1(data1), .data2(data2), .immediate(immediate),
        .rs1_2(rs1_2), .rs2_2(rs2_2), .rd_2(rd_2),
        .write_back_2(write_back_2), .mem_2(mem_2), .alu_op_2(alu_op_2),
        .alu_src_2(alu_src_2), .writeback_data_5(writeback_data_5),
        .write_back_5(write_back_5), .rd_5(rd_5),
        .write_back_3(write_back_3), .mem_3(mem_3), .alu_result_3(alu_result_3),
        .writedata_3(writedata_3), .rd_3(rd_3), .ex_stall(ex_stall)
    );

    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] rf,
                                        input logic use_ex);
        if (use_ex && m_wb3 && m_rd3 != 0 && m_rd3 == rs) return m_res3;
        if (write_back_5 && rd_5 != 0 && rd_5 == rs) return writeback_data_5;
        return rf;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int          sa, sb;
        longint      p;
        logic [63:0] u;
        logic        ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            5'd1:  return a - b;
            5'd2:  return a & b;
            5'd3:  return a | b;
            5'd4:  return a ^ b;
            5'd5:  return a << b[4:0];
            5'd6:  return a >> b[4:0];
            5'd7:  return 32'(sa >>> b[4:0]);
            5'd8:  return (sa < sb) ? 32'd1 : 32'd0;
            5'd9:  return (a < b) ? 32'd1 : 32'd0;
            5'd10: return a * b;
            5'd11: begin p = longint'(sa) * longint'(sb); u = p; return u[63:32]; end
            5'd12: begin u = {32'd0, a} * {32'd0, b}; return u[63:32]; end
            5'd13: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
            5'd14: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            5'd15: return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
            5'd16: return (b == 0) ? a : a % b;
            default: return a + b;
        endcase
    endfunction

    // Present one op, check its stall length, optionally hold memory_stall in
    // the accept cycle, then let it load into EX/MEM.
    task automatic issue(input logic [4:0] op, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] imm, input logic src, input logic [4:0] r1,
                         input logic [4:0] r2, input logic [4:0] rd, input logic [1:0] mem,
                         input int run_pulse, input int done_hold);
        logic [31:0] f1, f2, op2, res, held_res;
        logic        ism, shrt, held_wb;
        int          exp_stall, n;
        exp_t        e;
        alu_op_2 = op; data1 = d1; data2 = d2; immediate = imm; alu_src_2 = src;
        rs1_2 = r1; rs2_2 = r2; rd_2 = rd; mem_2 = mem; write_back_2 = 1'b1;
        flush = 1'b0; memory_stall = 1'b0;
        f1   = fwd(r1, d1, 1'b1);
        f2   = fwd(r2, d2, 1'b1);
        ism  = (op >= 5'd10) && (op <= 5'd16);
        op2  = (src && !ism) ? imm : f2;
        res  = ref_alu(op, f1, op2);
        shrt = ism && (op >= 5'd13) && ((f2 == 0) ||
               ((op == 5'd13 || op == 5'd15) && f1 == 32'h8000_0000 && f2 == 32'hFFFF_FFFF));
        exp_stall = !ism ? 0 : (shrt ? 1 : XLEN + 1);
        e.rd = rd; e.res = res; e.mem = mem;
        e.wd = ism ? fwd(r2, d2, 1'b0) : f2;  // EX/MEM holds a bubble by the load cycle
        exp_q.push_back(e);
        n = 0;
        #1;
        while (ex_stall && n < 100) begin
            n++;
            @(negedge clk);
            memory_stall = (n == run_pulse);
            #1;
        end
        check("ex_stall_cycles", 64'(n), 64'(exp_stall));
        if (ism)
            check("stall_bubble", {62'd0, write_back_3, |mem_3}, 64'd0);
        for (int k = 0; k < done_hold; k++) begin
            memory_stall = 1'b1;
            held_res = alu_result_3;
            held_wb  = write_back_3;
            @(negedge clk);
            check("mem_stall_hold", {31'd0, held_wb, held_res}, {31'd0, write_back_3, alu_result_3});
        end
        memory_stall = 1'b0;
        @(negedge clk);
        m_wb3 = 1'b1; m_rd3 = rd; m_res3 = res;
    endtask

    task automatic idle(input int cycles);
        alu_op_2 = '0; write_back_2 = 1'b0; rd_2 = '0; mem_2 = '0; alu_src_2 = 1'b0;
        flush = 1'b0; memory_stall = 1'b0;
        repeat (cycles) @(negedge clk);
        m_wb3 = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom();
        endcase
    endfunction

    // Monitor: each newly registered writeback result is matched against the queue.
    always @(posedge clk) begin
        logic ms;
        exp_t e;
        ms = memory_stall;
        #1;
        if (rst_n && !ms && write_back_3) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_result actual rd=%0d res=%08h", rd_3, alu_result_3);
            end else begin
                e = exp_q.pop_front();
                if (rd_3 !== e.rd || alu_result_3 !== e.res || writedata_3 !== e.wd || mem_3 !== e.mem) begin
                    failures++;
                    $display("FAIL exmem_result actual rd=%0d res=%08h wd=%08h mem=%0d required rd=%0d res=%08h wd=%08h mem=%0d",
                             rd_3, alu_result_3, writedata_3, mem_3, e.rd, e.res, e.wd, e.mem);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; memory_stall = 1'b0; flush = 1'b0;
        data1 = '0; data2 = '0; immediate = '0; writeback_data_5 = '0;
        rs1_2 = '0; rs2_2 = '0; rd_2 = '0; rd_5 = '0; alu_op_2 = '0;
        write_back_2 = 1'b0; alu_src_2 = 1'b0; write_back_5 = 1'b0; mem_2 = '0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {write_back_3, mem_3, alu_result_3, writedata_3, rd_3, ex_stall}, '0);
        rst_n = 1'b1;
        @(negedge clk);

        // Forwarding: EX/MEM beats MEM/WB, then MEM/WB-only hit.
        issue(5'd0, 32'd2, 32'd3, 32'd0, 1'b0, 5'd0, 5'd0, 5'd1, 2'd0, 0, 0);
        write_back_5 = 1'b1; rd_5 = 5'd1; writeback_data_5 = 32'd99;
        issue(5'd0, 32'hDEAD, 32'd7, 32'd0, 1'b0, 5'd1, 5'd2, 5'd2, 2'd1, 0, 0);
        rd_5 = 5'd3; writeback_data_5 = 32'd50;
        issue(5'd1, 32'd0, 32'd0, 32'd0, 1'b0, 5'd3, 5'd2, 5'd3, 2'd0, 0, 0);
        write_back_5 = 1'b0;
        // Shift amount uses only the low 5 bits of the immediate.
        issue(5'd5, 32'd1, 32'd0, 32'h21, 1'b1, 5'd0, 5'd0, 5'd4, 2'd0, 0, 0);
        // MULH, division corner cases, memory_stall during RUN and DONE.
        issue(5'd11, 32'hFFFF_FFFE, 32'd3, 32'd0, 1'b0, 5'd0, 5'd0, 5'd6, 2'd2, 0, 0);
        issue(5'd13, 32'd7, 32'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd7, 2'd0, 0, 0);
        issue(5'd15, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 5'd0, 5'd0, 5'd8, 2'd0, 0, 0);
        issue(5'd14, 32'd100, 32'd7, 32'd0, 1'b0, 5'd0, 5'd0, 5'd9, 2'd0, 10, 3);
        // Back-to-back M ops.
        issue(5'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 5'd0, 5'd0, 5'd10, 2'd0, 0, 0);
        issue(5'd16, 32'd12345, 32'd100, 32'd0, 1'b0, 5'd0, 5'd0, 5'd11, 2'd0, 0, 0);

        // Flush of a single-cycle op loads a bubble over a live result.
        alu_op_2 = 5'd0; data1 = 32'd9; data2 = 32'd9; rd_2 = 5'd7; write_back_2 = 1'b1; flush = 1'b1;
        @(negedge clk);
        idle(0);
        #1;
        check("flush_bubble", {write_back_3, mem_3, alu_result_3, writedata_3, rd_3}, '0);
        m_wb3 = 1'b0;

        // Flush at RUN cycle 10; the following M op must see a fresh IDLE.
        alu_op_2 = 5'd11; data1 = 32'd5; data2 = 32'd6; rs1_2 = '0; rs2_2 = '0;
        rd_2 = 5'd12; write_back_2 = 1'b1;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush_ex_stall", {63'd0, ex_stall}, 64'd0);
        @(negedge clk);
        idle(0);
        #1;
        check("flush_run_bubble", {62'd0, write_back_3, ex_stall}, 64'd0);
        issue(5'd10, 32'd300, 32'd7, 32'd0, 1'b0, 5'd0, 5'd0, 5'd13, 2'd3, 0, 0);

        // Asynchronous reset mid-RUN while EX/MEM holds a live result.
        issue(5'd0, 32'h1234, 32'd1, 32'd0, 1'b0, 5'd0, 5'd0, 5'd3, 2'd1, 0, 0);
        alu_op_2 = 5'd10; data1 = 32'd3; data2 = 32'd5; rd_2 = 5'd4; memory_stall = 1'b1;
        repeat (6) @(negedge clk);
        check("pre_reset_live", {62'd0, write_back_3, ex_stall}, 64'd3);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {write_back_3, mem_3, alu_result_3, writedata_3, rd_3}, '0);
        idle(0);
        #1;
        check("reset_ex_stall", {63'd0, ex_stall}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_wb3 = 1'b0;
        @(negedge clk);
        issue(5'd13, 32'hFFFF_FF9C, 32'd7, 32'd0, 1'b0, 5'd0, 5'd0, 5'd5, 2'd0, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 200; i++) begin
            logic [4:0] op;
            op = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 2) == 0) op = 5'($urandom_range(10, 16));
            write_back_5     = 1'($urandom_range(0, 1));
            rd_5             = 5'($urandom_range(0, 3));
            writeback_data_5 = pick();
            issue(op, pick(), pick(), $urandom(), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), int'($urandom_range(2, 30)),
                  ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 2)) : 0);
        end

        idle(3);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/execute_stage_md.md
# execute_stage_md

Parametrised next-generation execute stage: a single-cycle ALU, two-level operand forwarding and the EX/MEM pipeline register, extended with an iterative multiply/divide unit (RV32M-style). It sits between the ID/EX register and the memory stage. Multi-cycle ops stall upstream via `ex_stall`. `memory_stall` freezes the EX/MEM register, and `flush` cancels the op held in ID/EX.

## Interface
- `XLEN`, 32, datapath width; power of two, ≥ 8.
- `REG_W`, 5, register-index width.
- `SHAMT_W`, `$clog2(XLEN)`, shift-amount bits taken from operand 2.
- `clk` input 1: the block's single clock; all state changes on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `memory_stall` input 1: hold the EX/MEM register.
- `flush` input 1: kill the op in ID/EX and abort any M op.
- `data1`, `data2`, `immediate` input XLEN each: register-file operands and immediate.
- `rs1_2`, `rs2_2`, `rd_2` input REG_W each: source and destination indices.
- `write_back_2` input 1: register-write control for the ID/EX op.
- `mem_2` input 2: memory control for the ID/EX op.
- `alu_op_2` input 5: operation code.
- `alu_src_2` input 1: 1 selects `immediate` as operand 2.
- `writeback_data_5` input XLEN: MEM/WB forwarding value.
- `write_back_5` input 1: MEM/WB register-write control.
- `rd_5` input REG_W: MEM/WB destination index.
- `write_back_3` output 1: EX/MEM register-write control.
- `mem_3` output 2: EX/MEM memory control.
- `alu_result_3`, `writedata_3` output XLEN each: EX/MEM result and store data.
- `rd_3` output REG_W: EX/MEM destination index.
- `ex_stall` output 1, combinational: upstream holds ID/EX while high.

## Operation
- **Forwarding (per source)**
  - EX/MEM hit (`write_back_3`, `rd_3`≠0, `rd_3`==rs) is selected over a MEM/WB hit (`write_back_5`, `rd_5`≠0, `rd_5`==rs); otherwise the register-file value is used.
  - The forwarded rs2 value, `fwd2`, is the store data.
  - Operand 2 is `alu_src_2 ? immediate : fwd2`.
- **Single-cycle op codes (0–9):** ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT (signed), SLTU.
  - Shifts use operand2[SHAMT_W-1:0] only.
  - Add and subtract are modulo 2^XLEN.
- **Multi-cycle op codes (10–16):** MUL (low XLEN bits), MULH (signed×signed), MULHU, DIV, DIVU, REM, REMU.
  - Codes 17–31 behave as ADD.
- **M-unit state machine IDLE → RUN → DONE → IDLE**
  - **IDLE:** an M op in ID/EX with no `flush` captures the forwarded operands (operand 2 is `fwd2`; `alu_src_2` is ignored).
    - Signed ops take magnitudes and record the result sign.
    - Next state is RUN, iteration counter = 0.
  - **IDLE shortcut:** DIV/DIVU/REM/REMU with divisor 0, or signed DIV/REM with dividend −2^(XLEN−1) and divisor −1, go directly to DONE with the result preloaded:
    - divisor 0: quotient all-ones, remainder = dividend;
    - overflow: quotient = dividend, remainder 0.
  - **RUN:** one radix-2 step per cycle (shift-add multiply or restoring divide).
    - Runs for XLEN cycles, then DONE with sign correction applied.
    - Iteration continues while `memory_stall` is high.
  - **DONE:** the result is presented to the EX/MEM register.
    - Returns to IDLE at the first edge with `memory_stall` low; stays in DONE otherwise.
- **ex_stall:** high when an M op is in ID/EX and the state is not DONE; `flush` forces it low.
- **EX/MEM register update priority** (checked in order):
  - `memory_stall`: hold all fields.
  - `flush` or `ex_stall`: load a bubble (`write_back_3`=0, `mem_3`=0, `rd_3`=0, data 0).
  - Otherwise load the op's result, controls, `rd_2` and `fwd2`.
- **flush:** the FSM returns to IDLE on the next edge from any state, discarding partial results.

## Timing
- **Reset:** all outputs 0, FSM in IDLE, counter 0; asynchronous on `rst_n` low, including mid-iteration.
- **Single-cycle ops:** result appears on `alu_result_3` one edge after presentation.
- **Normal M op:**
  - `ex_stall` is high for XLEN+1 cycles (the issue cycle plus XLEN RUN cycles).
  - The result is registered at the end of cycle XLEN+2 after presentation (34 for XLEN=32).
  - Bubbles are inserted meanwhile.
- **Shortcut M op:** `ex_stall` is high for 1 cycle; the result is registered at the end of cycle 2.
- **Operands:** captured at issue only; later changes on forwarding inputs during RUN do not affect the result.
- **Back-to-back M ops:** the second issues in the cycle after DONE (IDLE again).

## Test plan
- ADD with rs1 matching both `rd_3` and `rd_5` → EX/MEM value used.
  - Example: 5 + 7 = 12 at `alu_result_3` after 1 edge.
- SLL with operand2 = 0x0000_0021, XLEN=32 → shift by 1.
  - Example: 0x1 gives 0x2.
- MULH with 0xFFFF_FFFE × 0x0000_0003 → `ex_stall` high 33 cycles, then `alu_result_3`=0xFFFF_FFFF.
  - Bubbles are observed on `write_back_3`/`mem_3` during the stall.
- Division corner cases:
  - DIV with 7 / 0 → `ex_stall` high 1 cycle, result 0xFFFF_FFFF.
  - REM with 0x8000_0000 % −1 → 0.
- DIVU 100/7 with `memory_stall` pulsed during RUN and for 3 cycles in DONE.
  - Result 14 is held in DONE until the stall drops; EX/MEM is unchanged while the stall is high.
- Interrupting an M op:
  - `flush` at RUN cycle 10 → FSM IDLE next edge, `ex_stall` low, bubble loaded.
  - `rst_n` low mid-RUN → all outputs 0 immediately.
